// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one synchronous memory port between NREQ requesters,
// with per-requester lock for atomic bursts and tagged read-data return after RD_LAT cycles.
module mem_arbiter #(
    parameter int NREQ   = 2,
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_val_i,
    input  logic [NREQ-1:0]    req_wen_i,
    input  logic [NREQ-1:0]    req_lock_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]    req_rdy_o,
    output logic [NREQ-1:0]    rsp_val_o,
    output logic [DW-1:0]      rsp_data_o,
    output logic               mem_val_o,
    output logic               mem_wen_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [DW-1:0]      mem_wdata_o,
    input  logic [DW-1:0]      mem_rdata_i
);
    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic          r_tv  [RD_LAT];
    logic [IW-1:0] r_tid [RD_LAT];

    logic [IW-1:0] w_g;
    logic [IW:0]   w_k;
    logic          w_found;
    logic          w_xfer;

    // Scan downwards so the nearest requester after the pointer is the last one to win.
    always_comb begin
        w_g     = r_owner;
        w_found = 1'b0;
        w_k     = '0;
        if (r_state == LOCKED) begin
            w_found = req_val_i[r_owner];
        end else begin
            for (int i = NREQ; i >= 1; i--) begin
                w_k = {1'b0, r_ptr} + (IW+1)'(i);
                w_k = (w_k >= (IW+1)'(NREQ)) ? w_k - (IW+1)'(NREQ) : w_k;
                if (req_val_i[w_k[IW-1:0]]) begin
                    w_g     = w_k[IW-1:0];
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_xfer      = w_found & rst_ni;
    assign req_rdy_o   = w_xfer ? (NREQ'(1) << w_g) : '0;
    assign mem_val_o   = w_xfer;
    assign mem_wen_o   = w_xfer & req_wen_i[w_g];
    assign mem_addr_o  = w_xfer ? req_addr_i[int'(w_g)*AW +: AW] : '0;
    assign mem_wdata_o = w_xfer ? req_wdata_i[int'(w_g)*DW +: DW] : '0;

    assign rsp_val_o  = r_tv[RD_LAT-1] ? (NREQ'(1) << r_tid[RD_LAT-1]) : '0;
    assign rsp_data_o = r_tv[RD_LAT-1] ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ARB;
            r_ptr   <= IW'(NREQ-1);
            r_owner <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tv[i]  <= 1'b0;
                r_tid[i] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_ptr   <= w_g;
                r_owner <= w_g;
                r_state <= req_lock_i[w_g] ? LOCKED : ARB;
            end else if (r_state == LOCKED && !req_lock_i[r_owner]) begin
                r_state <= ARB;
            end
            r_tv[0]  <= w_xfer & ~req_wen_i[w_g];
            r_tid[0] <= w_g;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tv[i]  <= r_tv[i-1];
                r_tid[i] <= r_tid[i-1];
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus on a 2-requester/RD_LAT=1 instance and a
// 3-requester/RD_LAT=3 instance, with memory models and read-response scoreboards.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic [1:0]  a_val = '0, a_wen = '0, a_lock = '0, a_rdy, a_rsp;
    logic [15:0] a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic [15:0] a_rsp_data, a_mwdata;
    logic [15:0] a_rdata = '0;
    logic        a_mval, a_mwen;
    logic [7:0]  a_maddr;

    logic [2:0]  b_val = '0, b_wen = '0, b_lock = '0, b_rdy, b_rsp;
    logic [23:0] b_addr = '0;
    logic [47:0] b_wdata = '0;
    logic [15:0] b_rsp_data, b_mwdata;
    logic [15:0] b_rdata = '0, b_p0 = '0, b_p1 = '0;
    logic        b_mval, b_mwen;
    logic [7:0]  b_maddr;

    mem_arbiter #(.NREQ(2), .AW(8), .DW(16), .RD_LAT(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_val_i(a_val), .req_wen_i(a_wen), .req_lock_i(a_lock),
        .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_rdy_o(a_rdy),
        .rsp_val_o(a_rsp), .rsp_data_o(a_rsp_data),
        .mem_val_o(a_mval), .mem_wen_o(a_mwen), .mem_addr_o(a_maddr),
        .mem_wdata_o(a_mwdata), .mem_rdata_i(a_rdata)
    );

    mem_arbiter #(.NREQ(3), .AW(8), .DW(16), .RD_LAT(3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_val_i(b_val), .req_wen_i(b_wen), .req_lock_i(b_lock),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_rdy_o(b_rdy),
        .rsp_val_o(b_rsp), .rsp_data_o(b_rsp_data),
        .mem_val_o(b_mval), .mem_wen_o(b_mwen), .mem_addr_o(b_maddr),
        .mem_wdata_o(b_mwdata), .mem_rdata_i(b_rdata)
    );

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : ({a, a} ^ 16'h5A5A);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory macros: unwritten locations return init_val().
    logic [255:0] mw_a = '0, mw_b = '0;
    logic [15:0]  mem_a [256];
    logic [15:0]  mem_b [256];

    always @(posedge clk) begin
        if (a_mval && a_mwen) begin
            mem_a[a_maddr] <= a_mwdata;
            mw_a[a_maddr]  <= 1'b1;
        end else if (a_mval) begin
            a_rdata <= mw_a[a_maddr] ? mem_a[a_maddr] : init_val(a_maddr);
        end
    end

    always @(posedge clk) begin
        if (b_mval && b_mwen) begin
            mem_b[b_maddr] <= b_mwdata;
            mw_b[b_maddr]  <= 1'b1;
        end else if (b_mval) begin
            b_p0 <= mw_b[b_maddr] ? mem_b[b_maddr] : init_val(b_maddr);
        end
        b_p1    <= b_p0;
        b_rdata <= b_p1;
    end

    // Reference memories built from the requesters' own write intent.
    logic [255:0] rw_a = '0, rw_b = '0;
    logic [15:0]  rm_a [256];
    logic [15:0]  rm_b [256];

    always @(negedge rst_n) begin
        qa.delete();
        qb.delete();
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                e = qa.pop_front();
                chk("a_rsp_val", 32'(a_rsp), 32'(1) << e.id);
                chk("a_rsp_data", 32'(a_rsp_data), 32'(e.data));
            end else begin
                chk("a_rsp_idle", 32'({a_rsp, a_rsp_data}), 0);
            end
            chk("a_rdy_onehot", 32'($onehot0(a_rdy)), 1);
            chk("a_rdy_needs_val", 32'(a_rdy & ~a_val), 0);
            chk("a_mval", 32'(a_mval), 32'(|a_rdy));
            if (!a_mval) chk("a_mem_idle", 32'({a_mwen, a_maddr, a_mwdata}), 0);
            for (int n = 0; n < 2; n++) begin
                if (a_rdy[n]) begin
                    chk("a_mwen", 32'(a_mwen), 32'(a_wen[n]));
                    chk("a_maddr", 32'(a_maddr), 32'(a_addr[n*8 +: 8]));
                    if (a_wen[n]) begin
                        chk("a_mwdata", 32'(a_mwdata), 32'(a_wdata[n*16 +: 16]));
                        rm_a[a_addr[n*8 +: 8]] <= a_wdata[n*16 +: 16];
                        rw_a[a_addr[n*8 +: 8]] <= 1'b1;
                    end else begin
                        qa.push_back('{cyc + 1, n, rw_a[a_addr[n*8 +: 8]] ?
                            rm_a[a_addr[n*8 +: 8]] : init_val(a_addr[n*8 +: 8])});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (qb.size() > 0 && qb[0].due == cyc) begin
                e = qb.pop_front();
                chk("b_rsp_val", 32'(b_rsp), 32'(1) << e.id);
                chk("b_rsp_data", 32'(b_rsp_data), 32'(e.data));
            end else begin
                chk("b_rsp_idle", 32'({b_rsp, b_rsp_data}), 0);
            end
            chk("b_rdy_onehot", 32'($onehot0(b_rdy)), 1);
            chk("b_rdy_needs_val", 32'(b_rdy & ~b_val), 0);
            chk("b_mval", 32'(b_mval), 32'(|b_rdy));
            if (!b_mval) chk("b_mem_idle", 32'({b_mwen, b_maddr, b_mwdata}), 0);
            for (int n = 0; n < 3; n++) begin
                if (b_rdy[n]) begin
                    chk("b_mwen", 32'(b_mwen), 32'(b_wen[n]));
                    chk("b_maddr", 32'(b_maddr), 32'(b_addr[n*8 +: 8]));
                    if (b_wen[n]) begin
                        chk("b_mwdata", 32'(b_mwdata), 32'(b_wdata[n*16 +: 16]));
                        rm_b[b_addr[n*8 +: 8]] <= b_wdata[n*16 +: 16];
                        rw_b[b_addr[n*8 +: 8]] <= 1'b1;
                    end else begin
                        qb.push_back('{cyc + 3, n, rw_b[b_addr[n*8 +: 8]] ?
                            rm_b[b_addr[n*8 +: 8]] : init_val(b_addr[n*8 +: 8])});
                    end
                end
            end
        end
    end

    task automatic step_a(input logic [1:0] rdy);
        @(negedge clk);
        chk("a_rdy", 32'(a_rdy), 32'(rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [2:0] rdy);
        @(negedge clk);
        chk("b_rdy", 32'(b_rdy), 32'(rdy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: requests present but nothing may be granted.
        a_val = 2'b11;
        b_val = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_rdy", 32'(a_rdy), 0);
        chk("rst_b_rdy", 32'(b_rdy), 0);
        chk("rst_a_out", 32'({a_rsp, a_mval}), 0);
        chk("rst_b_out", 32'({b_rsp, b_mval}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_val = '0;
        b_val = '0;

        // Single read of mem[0x10] by requester 0.
        a_addr = {8'h00, 8'h10};
        a_val  = 2'b01;
        step_a(2'b01);
        a_val = '0;
        @(negedge clk);
        chk("t1_rsp", 32'(a_rsp), 32'h1);
        chk("t1_data", 32'(a_rsp_data), 32'hBEEF);
        @(posedge clk);
        #1;

        // Lone requester keeps the grant every cycle.
        a_addr = {8'h00, 8'h11};
        a_val  = 2'b01;
        repeat (3) step_a(2'b01);

        // Both requesters continuously: strict alternation, pointer last at 0.
        a_addr = {8'h30, 8'h31};
        a_val  = 2'b11;
        for (int i = 0; i < 6; i++) step_a(i[0] ? 2'b01 : 2'b10);
        a_val = '0;
        step_a(2'b00);

        // Locked write by requester 1, owner idle while locked, then unlocked read-back.
        a_addr  = {8'h20, 8'h40};
        a_wdata = {16'h1234, 16'h0000};
        a_wen   = 2'b10;
        a_lock  = 2'b10;
        a_val   = 2'b11;
        step_a(2'b10);
        a_val = 2'b01;
        step_a(2'b00);
        a_val  = 2'b11;
        a_wen  = 2'b00;
        a_lock = 2'b00;
        step_a(2'b10);
        a_val = 2'b01;
        @(negedge clk);
        chk("t3_rdy", 32'(a_rdy), 32'h1);
        chk("t3_rsp", 32'(a_rsp), 32'h2);
        chk("t3_data", 32'(a_rsp_data), 32'h1234);
        @(posedge clk);
        #1;

        // Lock dropped while the owner is idle: still locked this cycle, open next.
        a_addr  = {8'h21, 8'h40};
        a_wdata = {16'h5555, 16'h0000};
        a_wen   = 2'b10;
        a_lock  = 2'b10;
        a_val   = 2'b10;
        step_a(2'b10);
        a_wen  = 2'b00;
        a_lock = 2'b00;
        a_val  = 2'b01;
        step_a(2'b00);
        step_a(2'b01);
        a_val = '0;
        step_a(2'b00);

        // Back-to-back reads with RD_LAT=3 from requesters 0 and 1.
        b_addr = {8'h00, 8'h02, 8'h01};
        b_val  = 3'b011;
        step_b(3'b001);
        b_val = 3'b010;
        step_b(3'b010);
        b_val = '0;
        step_b(3'b000);
        @(negedge clk);
        chk("t4_rsp0", 32'(b_rsp), 32'h1);
        chk("t4_data0", 32'(b_rsp_data), 32'(init_val(8'h01)));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_rsp1", 32'(b_rsp), 32'h2);
        chk("t4_data1", 32'(b_rsp_data), 32'(init_val(8'h02)));
        @(posedge clk);
        #1;

        // Read accepted, then reset: its response must never appear.
        a_addr = {8'h00, 8'h10};
        a_val  = 2'b01;
        @(negedge clk);
        chk("t5_rdy", 32'(a_rdy), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        a_val = 2'b11;
        @(negedge clk);
        chk("t5_no_rsp", 32'(a_rsp), 0);
        chk("t5_rst_rdy", 32'(a_rdy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step_a(2'b01);
        step_a(2'b10);
        a_val = '0;
        step_a(2'b00);

        // Three requesters all valid from reset pointer 2: 0,1,2 then wrap to 0.
        b_addr = {8'h52, 8'h51, 8'h50};
        b_val  = 3'b111;
        step_b(3'b001);
        step_b(3'b010);
        step_b(3'b100);
        step_b(3'b001);
        b_val = '0;
        repeat (5) step_b(3'b000);

        chk("a_drained", 32'(qa.size()), 0);
        chk("b_drained", 32'(qb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
